// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared definitions for the EX-stage multiply/divide unit.
//               Holds the md_op encodings, the default cycle counts, the
//               latency-counter width and the sequencing FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

  // md_op encodings driven by the decoder alongside start
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Default latencies from accept to HI/LO commit
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Counter width; supports latencies of 1..32 cycles
  localparam int MD_CNT_W = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // True for the multi-cycle ops (MULT/MULTU/DIV/DIVU)
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_latency_counter.sv
`default_nettype none
// ============================================================================
// Module      : md_latency_counter
// Description : IDLE/RUN sequencer for the multiply/divide unit. A load in
//               IDLE starts a countdown from load_val; the edge on which the
//               count has reached zero is the commit edge.
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   load     in   start a countdown (honoured in IDLE only)
//   load_val in   initial count (latency - 1)
//   busy     out  countdown in progress
//   done     out  high during the last busy cycle; the following rising
//                 edge is the commit edge
// Revision    : 1.0 - initial release
// ============================================================================
module md_latency_counter
  import md_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  output logic                busy,
  output logic                done
);

  md_state_t           r_state;
  md_state_t           w_state_nxt;
  logic [MD_CNT_W-1:0] r_count;
  logic [MD_CNT_W-1:0] w_count_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    done        = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = load_val;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_count == '0) begin
          // Last busy cycle: commit and return to IDLE on the same edge
          done        = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : EX-stage multiply/divide unit with HI/LO registers.
//               MULT/MULTU/DIV/DIVU results are computed at accept, held in
//               pending registers and committed to HI/LO after a fixed
//               latency. MTHI/MTLO write HI/LO in a single cycle.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   valid MD op in EX this cycle
//   md_op  in   operation select (see md_pkg)
//   src_a  in   forwarded rs operand
//   src_b  in   forwarded rt operand
//   busy   out  multi-cycle op in flight
//   hi     out  HI register
//   lo     out  LO register
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MD_CNT_W-1:0] c_mult_load = MD_CNT_W'(MULT_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] c_div_load  = MD_CNT_W'(DIV_CYCLES - 1);

  logic                w_accept;
  logic                w_load;
  logic [MD_CNT_W-1:0] w_load_val;
  logic                w_done;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_wr;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_wr;

  // Arithmetic
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_zero;
  logic [31:0] w_divisor_u;
  logic [31:0] w_uquot;
  logic [31:0] w_urem;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_squot_mag;
  logic [31:0] w_srem_mag;
  logic [31:0] w_squot;
  logic [31:0] w_srem;

  // Start while busy is dropped entirely, including MTHI/MTLO
  assign w_accept   = start && !busy;
  assign w_load     = w_accept && md_is_long(md_op);
  // md_op[1] separates DIV/DIVU from MULT/MULTU among the long ops
  assign w_load_val = md_op[1] ? c_div_load : c_mult_load;

  md_latency_counter u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .busy     (busy),
    .done     (w_done)
  );

  // Sign-extending to 64 bits makes the low 64 bits of the product the
  // two's-complement signed result.
  assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Divisor forced to 1 on zero so the dividers never see x; the result is
  // discarded by the pending write flag in that case anyway.
  assign w_div_zero  = (src_b == 32'd0);
  assign w_divisor_u = w_div_zero ? 32'd1 : src_b;
  assign w_uquot     = src_a / w_divisor_u;
  assign w_urem      = src_a % w_divisor_u;

  // Signed divide on magnitudes. The magnitude of 0x80000000 is 0x80000000
  // as an unsigned value, so 0x80000000 / -1 naturally yields 0x80000000
  // with remainder 0.
  assign w_abs_a     = src_a[31] ? (32'd0 - src_a) : src_a;
  assign w_abs_b     = w_div_zero ? 32'd1 :
                       (src_b[31] ? (32'd0 - src_b) : src_b);
  assign w_squot_mag = w_abs_a / w_abs_b;
  assign w_srem_mag  = w_abs_a % w_abs_b;
  assign w_squot     = (src_a[31] ^ src_b[31]) ? (32'd0 - w_squot_mag) : w_squot_mag;
  assign w_srem      = src_a[31] ? (32'd0 - w_srem_mag) : w_srem_mag;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b0;
    case (md_op)
      MD_MULT: begin
        {w_res_hi, w_res_lo} = w_prod_s;
        w_res_wr = 1'b1;
      end
      MD_MULTU: begin
        {w_res_hi, w_res_lo} = w_prod_u;
        w_res_wr = 1'b1;
      end
      MD_DIV: begin
        w_res_hi = w_srem;
        w_res_lo = w_squot;
        w_res_wr = !w_div_zero;
      end
      MD_DIVU: begin
        w_res_hi = w_urem;
        w_res_lo = w_uquot;
        w_res_wr = !w_div_zero;
      end
      default: begin
        w_res_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else if (w_load) begin
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_pend_wr <= w_res_wr;
    end
  end

  // Commit and MTHI/MTLO are mutually exclusive: commit needs busy,
  // accept needs !busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_done) begin
      if (r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_accept) begin
      if (md_op == MD_MTHI) r_hi <= src_a;
      if (md_op == MD_MTLO) r_lo <= src_a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit, with a second
//               instance built for single-cycle multiply latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy1;
  logic [31:0] hi1;
  logic [31:0] lo1;

  int n_checks;
  int n_fail;

  md_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  md_unit #(.MULT_CYCLES(1), .DIV_CYCLES(2)) dut_n1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy1),
    .hi    (hi1),
    .lo    (lo1)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  // Present an op for exactly one rising edge; returns 1ns after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts busy cycles (sampled at negedge) until busy drops, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
  endtask

  task automatic test_reset;
    clk_en = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst_n = 1'b1;
    issue(MD_MTHI, 32'h55, 32'd0);
    issue(MD_MTLO, 32'h66, 32'd0);
    @(negedge clk);
    n_checks++; if (hi !== 32'h55 || lo !== 32'h66) begin n_fail++; $display("FAIL preload: got hi=%h lo=%h want 55/66", hi, lo); end
    // Reset with the clock stopped must still clear asynchronously
    clk_en = 1'b0;
    #20;
    rst_n = 1'b0;
    #1;
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_noclk: got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy); end
    #10;
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult;
    int cnt;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(cnt);
    n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", cnt); end
    n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult: got hi=%h lo=%h want ffffffff/fffffffa", hi, lo); end
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(cnt);
    n_checks++; if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL multu: got hi=%h lo=%h want 00000002/fffffffa", hi, lo); end
    issue(MD_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_idle(cnt);
    n_checks++; if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_minmin: got hi=%h lo=%h want 40000000/00000000", hi, lo); end
  endtask

  task automatic test_div;
    int cnt;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cnt);
    n_checks++; if (cnt != 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", cnt); end
    n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo); end
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle(cnt);
    n_checks++; if (hi !== 32'd1 || lo !== 32'd3) begin n_fail++; $display("FAIL divu: got hi=%h lo=%h want 1/3", hi, lo); end
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(cnt);
    n_checks++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb: got hi=%h lo=%h want 1/fffffffd", hi, lo); end
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cnt);
    n_checks++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf: got hi=%h lo=%h want 0/80000000", hi, lo); end
    issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cnt);
    n_checks++; if (hi !== 32'd1 || lo !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL divu_big: got hi=%h lo=%h want 1/7ffffffc", hi, lo); end
  endtask

  task automatic test_div_zero;
    int cnt;
    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    issue(MD_DIVU, 32'd1234, 32'd0);
    wait_idle(cnt);
    n_checks++; if (cnt != 10) begin n_fail++; $display("FAIL divz_busy_cycles: got %0d want 10", cnt); end
    n_checks++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL divu_zero: got hi=%h lo=%h want 11/22", hi, lo); end
    issue(MD_DIV, 32'hFFFF_FF00, 32'd0);
    wait_idle(cnt);
    n_checks++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL div_zero: got hi=%h lo=%h want 11/22", hi, lo); end
  endtask

  task automatic test_busy_ignore;
    int cnt;
    int extra;
    issue(MD_DIV, 32'd100, 32'd7);
    cnt = 0;
    @(negedge clk); if (busy) cnt++;
    start = 1'b1; md_op = MD_MULT; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk); if (busy) cnt++;
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    n_checks++; if (cnt != 10) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d want 10", cnt); end
    n_checks++; if (hi !== 32'd2 || lo !== 32'd14) begin n_fail++; $display("FAIL ignore_result: got hi=%h lo=%h want 2/14", hi, lo); end
    extra = 0;
    repeat (8) begin @(negedge clk); if (busy) extra++; end
    n_checks++; if (extra != 0 || hi !== 32'd2 || lo !== 32'd14) begin n_fail++; $display("FAIL ignore_no_followup: got busy_cycles=%0d hi=%h lo=%h want 0/2/14", extra, hi, lo); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1; md_op = MD_MTHI; src_a = 32'hA; src_b = 32'd0;
    @(negedge clk);
    n_checks++; if (hi !== 32'hA || busy !== 1'b0) begin n_fail++; $display("FAIL mthi: got hi=%h busy=%b want a/0", hi, busy); end
    md_op = MD_MTLO; src_a = 32'hB;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (hi !== 32'hA || lo !== 32'hB || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_mt: got hi=%h lo=%h busy=%b want a/b/0", hi, lo, busy); end
    // Unused encodings must do nothing
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    issue(3'd7, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    n_checks++; if (hi !== 32'hA || lo !== 32'hB || busy !== 1'b0) begin n_fail++; $display("FAIL nop_op: got hi=%h lo=%h busy=%b want a/b/0", hi, lo, busy); end
  endtask

  task automatic test_reset_mid;
    int cnt;
    issue(MD_MTHI, 32'h99, 32'd0);
    issue(MD_MULT, 32'd7, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (busy) cnt++; end
    n_checks++; if (cnt != 0 || hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_mid_after: got busy_cycles=%0d hi=%h lo=%h want 0/0/0", cnt, hi, lo); end
  endtask

  task automatic test_n1;
    int cnt1;
    int cnt0;
    issue(MD_MULT, 32'd6, 32'd7);
    cnt1 = 0;
    cnt0 = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy1) cnt1++;
      if (busy)  cnt0++;
    end
    n_checks++; if (cnt1 != 1) begin n_fail++; $display("FAIL n1_busy_cycles: got %0d want 1", cnt1); end
    n_checks++; if (hi1 !== 32'd0 || lo1 !== 32'd42) begin n_fail++; $display("FAIL n1_result: got hi=%h lo=%h want 0/2a", hi1, lo1); end
    n_checks++; if (cnt0 != 5 || lo !== 32'd42) begin n_fail++; $display("FAIL n5_alongside: got busy_cycles=%0d lo=%h want 5/2a", cnt0, lo); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b1;
    rst_n    = 1'b0;
    start    = 1'b0;
    md_op    = 3'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_n1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
